// File: rtl/iddmm_result_sel.sv
// Result-select output stage for the IDDMM multiplier: buffers the raw and (a - p)
// word streams, picks one on cal_done by the sign bit, and drains it as a stream.
module iddmm_result_sel #(
  parameter int K      = 256,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fifo_wr_en_a,
  input  logic [K-1:0] fifo_wr_data_a,
  input  logic         fifo_wr_en_sub,
  input  logic [K-1:0] fifo_wr_data_sub,
  input  logic         cal_done,
  input  logic         cal_sign,
  output logic         in_ready,
  output logic         m_valid,
  output logic [K-1:0] m_data,
  output logic         m_last,
  input  logic         m_ready,
  output logic         m_sel,
  output logic         err_short,
  output logic         err_ovf
);

  // Output handshake: a word transfers on any clock edge where m_valid && m_ready;
  // m_data/m_last are held stable while m_valid && !m_ready.

  typedef enum logic {ST_COLLECT, ST_DRAIN} state_t;

  localparam logic [ADDR_W:0]   PTR_FULL = (ADDR_W+1)'(N);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  logic [K-1:0] buf_a [N];
  logic [K-1:0] buf_s [N];

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wa_q, wa_d, ws_q, ws_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              m_valid_q, m_valid_d;
  logic [K-1:0]      m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              m_sel_q, m_sel_d;
  logic              err_short_q, err_short_d;
  logic              err_ovf_q, err_ovf_d;

  logic              wr_a_en, wr_s_en;
  logic [ADDR_W:0]   wa_post, ws_post;
  logic [ADDR_W-1:0] rd_nxt;

  always_comb begin
    state_d     = state_q;
    wa_d        = wa_q;
    ws_d        = ws_q;
    rd_d        = rd_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    m_sel_d     = m_sel_q;
    err_short_d = err_short_q;
    err_ovf_d   = err_ovf_q;
    wr_a_en     = 1'b0;
    wr_s_en     = 1'b0;
    wa_post     = wa_q;
    ws_post     = ws_q;
    rd_nxt      = rd_q + ADDR_W'(1);

    case (state_q)
      ST_COLLECT: begin
        wr_a_en = fifo_wr_en_a   && (wa_q != PTR_FULL);
        wr_s_en = fifo_wr_en_sub && (ws_q != PTR_FULL);
        if ((fifo_wr_en_a && !wr_a_en) || (fifo_wr_en_sub && !wr_s_en)) begin
          err_ovf_d = 1'b1;
        end
        wa_post = wa_q + (ADDR_W+1)'(wr_a_en);
        ws_post = ws_q + (ADDR_W+1)'(wr_s_en);
        wa_d    = wa_post;
        ws_d    = ws_post;
        // Completion counts a write landing in the same cycle as cal_done.
        if (cal_done) begin
          if ((wa_post == PTR_FULL) && (ws_post == PTR_FULL)) begin
            state_d   = ST_DRAIN;
            m_sel_d   = cal_sign;
            rd_d      = '0;
            m_valid_d = 1'b1;
            // Word 0 was written in an earlier cycle because N >= 2.
            m_data_d  = cal_sign ? buf_s[0] : buf_a[0];
            m_last_d  = 1'b0;
          end else begin
            err_short_d = 1'b1;
            wa_d        = '0;
            ws_d        = '0;
          end
        end
      end

      ST_DRAIN: begin
        if (fifo_wr_en_a || fifo_wr_en_sub || cal_done) begin
          err_ovf_d = 1'b1;
        end
        if (m_ready) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            wa_d      = '0;
            ws_d      = '0;
            state_d   = ST_COLLECT;
          end else begin
            rd_d     = rd_nxt;
            m_data_d = m_sel_q ? buf_s[rd_nxt] : buf_a[rd_nxt];
            m_last_d = (rd_nxt == LAST_IDX);
          end
        end
      end

      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      wa_q        <= '0;
      ws_q        <= '0;
      rd_q        <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_sel_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wa_q        <= wa_d;
      ws_q        <= ws_d;
      rd_q        <= rd_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      m_sel_q     <= m_sel_d;
      err_short_q <= err_short_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // Buffer storage needs no reset; contents are only read after a full fill.
  always_ff @(posedge clk) begin
    if (wr_a_en) buf_a[wa_q[ADDR_W-1:0]] <= fifo_wr_data_a;
    if (wr_s_en) buf_s[ws_q[ADDR_W-1:0]] <= fifo_wr_data_sub;
  end

  assign in_ready  = (state_q == ST_COLLECT);
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign m_sel     = m_sel_q;
  assign err_short = err_short_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_iddmm_result_sel.sv
// Bench for iddmm_result_sel: table of result transactions plus hand-written reset
// and randomized sequences, checked against a queue-based model of the stage.
module tb_iddmm_result_sel;
  localparam int K = 256;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_wr_en_a, fifo_wr_en_sub, cal_done, cal_sign, m_ready;
  logic [K-1:0] fifo_wr_data_a, fifo_wr_data_sub;
  logic         in_ready, m_valid, m_last, m_sel, err_short, err_ovf;
  logic [K-1:0] m_data;

  iddmm_result_sel #(.K(K), .N(N)) dut (
    .clk(clk), .rst(rst),
    .fifo_wr_en_a(fifo_wr_en_a), .fifo_wr_data_a(fifo_wr_data_a),
    .fifo_wr_en_sub(fifo_wr_en_sub), .fifo_wr_data_sub(fifo_wr_data_sub),
    .cal_done(cal_done), .cal_sign(cal_sign),
    .in_ready(in_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .m_sel(m_sel), .err_short(err_short), .err_ovf(err_ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard and reference model
  int n_pass = 0;
  int n_chk  = 0;
  logic [K-1:0] exp_q[$];
  logic [K-1:0] mdl_a[$];
  logic [K-1:0] mdl_s[$];
  bit mdl_short, mdl_ovf, mdl_sel;

  typedef struct {
    int n_a;
    int n_s;
    bit sign;
    bit rnd;
    int rdy;
    bit strobe_mid;
    bit exp_drain;
    bit exp_short;
    bit exp_ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fifo_wr_en_a     = 1'b0;
    fifo_wr_en_sub   = 1'b0;
    fifo_wr_data_a   = '0;
    fifo_wr_data_sub = '0;
    cal_done         = 1'b0;
    cal_sign         = 1'b0;
  endtask

  function automatic logic [K-1:0] rnd_word();
    logic [K-1:0] w;
    for (int i = 0; i < K/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_clear();
    mdl_a.delete();
    mdl_s.delete();
    exp_q.delete();
    mdl_short = 0;
    mdl_ovf   = 0;
    mdl_sel   = 0;
  endtask

  // A result is accepted only if both candidates are complete; otherwise it is short.
  task automatic model_cal(input bit sign);
    if (mdl_a.size() == N && mdl_s.size() == N) begin
      exp_q   = sign ? mdl_s : mdl_a;
      mdl_sel = sign;
    end else begin
      mdl_short = 1;
    end
    mdl_a.delete();
    mdl_s.delete();
  endtask

  task automatic do_reset();
    idle_inputs();
    m_ready = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_sel", m_sel, 0);
    check("rst_m_data", m_data, 0);
    check("rst_err_short", err_short, 0);
    check("rst_err_ovf", err_ovf, 0);
    model_clear();
    step();
    rst = 1'b0;
  endtask

  // driver: streams words, cal_done on the final cycle together with the last writes
  task automatic send(input int n_a, input int n_s, input bit sign, input bit rnd);
    int len;
    len = (n_a > n_s) ? n_a : n_s;
    for (int c = 0; c < len; c++) begin
      idle_inputs();
      if (c < n_a) begin
        fifo_wr_en_a   = 1'b1;
        fifo_wr_data_a = rnd ? rnd_word() : K'(32'h100 + c);
        if (mdl_a.size() < N) mdl_a.push_back(fifo_wr_data_a);
        else mdl_ovf = 1;
      end
      if (c < n_s) begin
        fifo_wr_en_sub   = 1'b1;
        fifo_wr_data_sub = rnd ? rnd_word() : K'(32'h200 + c);
        if (mdl_s.size() < N) mdl_s.push_back(fifo_wr_data_sub);
        else mdl_ovf = 1;
      end
      if (c == len - 1) begin
        cal_done = 1'b1;
        cal_sign = sign;
      end
      if (c == 0) check("in_ready_collect", in_ready, 1);
      step();
    end
    model_cal(sign);
    idle_inputs();
  endtask

  // receiver: rdy 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
  task automatic drain(input int rdy, input bit strobe_mid, output int cycles);
    logic [K-1:0] held, exp_w;
    bit held_last, stalled;
    stalled = 0;
    cycles  = 0;
    check("m_sel", m_sel, mdl_sel);
    while (exp_q.size() > 0 && cycles < 400) begin
      case (rdy)
        0:       m_ready = 1'b1;
        1:       m_ready = (cycles % 4 == 0) || (cycles % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (strobe_mid && cycles == 3) begin
        fifo_wr_en_a   = 1'b1;
        fifo_wr_data_a = '1;
        cal_done       = 1'b1;
        mdl_ovf        = 1;
      end else begin
        fifo_wr_en_a = 1'b0;
        cal_done     = 1'b0;
      end
      check("m_valid_drain", m_valid, 1);
      if (stalled) begin
        check("m_data_stable", m_data, held);
        check("m_last_stable", m_last, held_last);
      end
      if (m_valid && m_ready) begin
        exp_w = exp_q.pop_front();
        check("m_data", m_data, exp_w);
        check("m_last", m_last, exp_q.size() == 0);
        stalled = 0;
      end else begin
        held      = m_data;
        held_last = m_last;
        stalled   = m_valid;
      end
      step();
      cycles++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout_words_left", exp_q.size(), 0);
      exp_q.delete();
    end
    m_ready = 1'b0;
    idle_inputs();
    check("in_ready_after_drain", in_ready, 1);
    check("m_valid_after_drain", m_valid, 0);
  endtask

  initial begin
    int cyc;
    logic [K-1:0] w;
    bit want_drain;
    idle_inputs();
    m_ready = 1'b0;
    rst = 1'b0;
    #3;
    do_reset();

    //          n_a n_s sign rnd rdy strb drain short ovf
    tbl[0] = '{16, 16, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{16, 16, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16, 16, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{16, 16, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16, 15, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{16, 16, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{17, 16, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{16, 16, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].n_a, tbl[i].n_s, tbl[i].sign, tbl[i].rnd);
      check("m_valid_latency", m_valid, tbl[i].exp_drain);
      if (tbl[i].exp_drain) begin
        drain(tbl[i].rdy, tbl[i].strobe_mid, cyc);
        if (tbl[i].rdy == 0) check("drain_cycles", cyc, N);
      end else begin
        for (int j = 0; j < 3; j++) begin
          check("no_valid_after_short", m_valid, 0);
          step();
        end
        check("in_ready_after_short", in_ready, 1);
      end
      check("err_short", err_short, tbl[i].exp_short);
      check("err_ovf", err_ovf, tbl[i].exp_ovf);
    end

    // reset in the middle of a drain, after word 5 has transferred
    do_reset();
    send(N, N, 1'b1, 1'b0);
    m_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      w = exp_q.pop_front();
      check("pre_reset_word", m_data, w);
      step();
    end
    rst = 1'b1;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_m_data", m_data, 0);
    check("midrst_m_sel", m_sel, 0);
    check("midrst_errors", {err_short, err_ovf}, 0);
    model_clear();
    m_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("postrst_no_valid", m_valid, 0);
    send(N, N, 1'b0, 1'b0);
    check("postrst_valid", m_valid, 1);
    drain(0, 1'b0, cyc);
    check("postrst_drain_cycles", cyc, N);

    // randomized transactions against the model
    for (int t = 0; t < 8; t++) begin
      send(N, $urandom_range(N - 1, N), 1'($urandom_range(0, 1)), 1'b1);
      want_drain = (exp_q.size() != 0);
      check("rnd_m_valid", m_valid, want_drain);
      if (want_drain) drain($urandom_range(0, 2), 1'b0, cyc);
      else step();
      check("rnd_err_short", err_short, mdl_short);
      check("rnd_err_ovf", err_ovf, mdl_ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
